toggle_monitor: RTL
===================

TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the monitored bus width.
REQ-002 SHALL have parameter WINDOW, default 16, the number of transitions per measurement window (>= 1).
REQ-003 SHALL have parameter ACCW, default 16, the accumulator/result width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port din, input, WIDTH, the monitored bus (e.g. a counter q output).
REQ-007 SHALL have port din_valid, input, 1, qualifying din on the current posedge.
REQ-008 SHALL have port out_count, output, ACCW, the total bit toggles in the last completed window.
REQ-009 SHALL have port out_peak, output, PW = clog2(WIDTH+1), the maximum single-transition Hamming distance in that window.
REQ-010 SHALL have port out_valid, output, 1, which is high while out_count/out_peak hold an unconsumed result.
REQ-011 SHALL have port out_ready, input, 1, the consumer accept; a transfer occurs on a posedge with out_valid & out_ready.
REQ-012 SHALL have port overrun, output, 1, a sticky flag for a dropped window result.

Function
REQ-013 SHALL implement a two-state FSM: UNPRIMED (no reference sample held) and RUN.
REQ-014 In UNPRIMED, a din_valid sample SHALL load the prev register with din, cause no toggle accounting, and move the FSM to RUN.
REQ-015 In RUN, each din_valid sample SHALL compute hd = popcount(din ^ prev), add hd to acc, update peak to max(peak, hd), load prev with din, and increment the transition counter tcnt.
REQ-016 Cycles with din_valid low SHALL change no internal state other than the output handshake.
REQ-017 acc SHALL saturate at 2^ACCW-1 and never wrap.
REQ-018 On the sample that brings tcnt to WINDOW, the result SHALL be acc+hd (saturated) and max(peak, hd).
REQ-019 The window-complete result SHALL appear on out_count/out_peak with out_valid=1 in the cycle after that posedge (latency 1).
REQ-020 On window completion, acc, peak and tcnt SHALL clear; prev keeps the completing sample, so the next window starts without re-priming.
REQ-021 Windows SHALL be back-to-back, with every transition counted in exactly one window.
REQ-022 out_valid, out_count and out_peak SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 On a transfer with no simultaneous completion, out_valid SHALL go low on the next cycle.
REQ-024 On a transfer and a window completion at the same posedge, the new result SHALL load and out_valid SHALL stay 1.
REQ-025 On a window completion while out_valid=1 and out_ready=0, the new result SHALL be discarded, the held result kept, and overrun set.
REQ-026 overrun SHALL clear only on reset.
REQ-027 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-028 reset=1 SHALL force, asynchronously: FSM=UNPRIMED, prev=0, acc=0, peak=0, tcnt=0, out_count=0, out_peak=0, out_valid=0, overrun=0.
REQ-029 A reset asserted mid-window SHALL discard the partial window; the first valid sample after release only primes.
REQ-030 Reset deassertion SHALL take effect on the posedge after release; no sample SHALL be accounted while reset=1.

Verification
REQ-031 Defaults, out_ready=1, din_valid=1 every cycle, din=0,1,2,...,16 (17 samples) -> one result: out_count=31, out_peak=5.
REQ-032 Continue din=17..32 with no gap -> second result: out_count=32, out_peak=6, no re-prime sample consumed.
REQ-033 din alternates 0x00000000/0xFFFFFFFF for 17 samples -> out_count=512, out_peak=32; with din held constant for 17 samples -> out_count=0, out_peak=0.
REQ-034 out_ready=0 and 34 counting samples -> first result (31/5) held stable, overrun=1 after the second window completes; then out_ready=1 -> 31/5 transferred, out_valid drops next cycle.
REQ-035 Reset pulsed after 8 counting samples, then din=0..16 -> result 31/5, proving the partial window was discarded and the first sample only primed.
REQ-036 din_valid toggled randomly while din=0..16 -> same 31/5 result, proving invalid cycles are not counted.

Source files
------------

// File: rtl/toggle_monitor.sv
// toggle_monitor: measures switching activity on a bus. Every qualified sample
// after the first is compared with the previous one. The number of flipped bits
// is summed over a window of WINDOW transitions. The largest single-transition
// flip count is also tracked. Each window result is offered on a valid/ready
// output. A sticky overrun flag records any result dropped because the consumer
// was not ready.
module toggle_monitor #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 16,
  parameter int ACCW   = 16,
  localparam int PW    = $clog2(WIDTH + 1),
  localparam int TW    = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [ACCW-1:0]  out_count,
  output logic [PW-1:0]    out_peak,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  typedef enum logic {
    S_UNPRIMED = 1'b0,
    S_RUN      = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_prime;
  logic             w_sample;

  logic [WIDTH-1:0] r_prev;
  logic [ACCW-1:0]  r_acc;
  logic [PW-1:0]    r_peak;
  logic [TW-1:0]    r_tcnt;

  logic [ACCW-1:0]  r_out_count;
  logic [PW-1:0]    r_out_peak;
  logic             r_out_valid;
  logic             r_overrun;

  logic [PW-1:0]    w_hd;
  logic [ACCW-1:0]  w_acc_sum;
  logic [PW-1:0]    w_peak_max;
  logic             w_done;
  logic             w_xfer;

  // Number of set bits in a bus word.
  function automatic logic [PW-1:0] f_popcount(input logic [WIDTH-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

  // Accumulator add that sticks at all-ones instead of wrapping.
  function automatic logic [ACCW-1:0] f_sat_add(input logic [ACCW-1:0] a,
                                                input logic [PW-1:0]   b);
    logic [ACCW:0] s;
    s = {1'b0, a} + (ACCW + 1)'(b);
    return s[ACCW] ? {ACCW{1'b1}} : s[ACCW-1:0];
  endfunction

  assign w_hd       = f_popcount(din ^ r_prev);
  assign w_acc_sum  = f_sat_add(r_acc, w_hd);
  assign w_peak_max = (w_hd > r_peak) ? w_hd : r_peak;
  // A counted sample that is the last transition of the window.
  assign w_done     = w_sample && (r_tcnt == TW'(WINDOW - 1));
  // out_ready only matters while a result is actually being offered.
  assign w_xfer     = r_out_valid && out_ready;

  // State register: tracks whether a reference sample is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_UNPRIMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: the first valid sample primes, every later one is counted.
  always_comb begin
    w_state_nxt = r_state;
    w_prime     = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      S_UNPRIMED: begin
        if (din_valid) begin
          w_prime     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_sample = din_valid;
      end
      default: begin
        w_state_nxt = S_UNPRIMED;
      end
    endcase
  end

  // Window accumulation; prev survives a window boundary so windows abut.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= '0;
      r_acc  <= '0;
      r_peak <= '0;
      r_tcnt <= '0;
    end else if (w_prime) begin
      r_prev <= din;
    end else if (w_sample) begin
      r_prev <= din;
      if (w_done) begin
        r_acc  <= '0;
        r_peak <= '0;
        r_tcnt <= '0;
      end else begin
        r_acc  <= w_acc_sum;
        r_peak <= w_peak_max;
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  // Result holding register and handshake; a result arriving while the
  // previous one is still unconsumed is dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_count <= '0;
      r_out_peak  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_done) begin
      if (!r_out_valid || out_ready) begin
        r_out_count <= w_acc_sum;
        r_out_peak  <= w_peak_max;
        r_out_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_count = r_out_count;
  assign out_peak  = r_out_peak;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule
